// File: rtl/cpunc_arb_pkg.sv
// Shared definitions for the two-requester AXI-Lite arbiter: FSM states,
// requester count and the AXI OKAY response code.
package cpunc_arb_pkg;

  localparam int   NUM_REQ = 2;
  localparam logic OKAY    = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP,
    RSP
  } state_t;

endpackage

// File: rtl/cpunc_rr_pick.sv
// Two-way request picker: on contention the requester not granted last wins,
// otherwise the lone requester is granted. A constant i_last=1 gives fixed priority.
module cpunc_rr_pick
  import cpunc_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_last,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cpunc_axi_arb.sv
// Arbitrates two single-beat requesters onto one AXI-Lite master port, one
// transaction at a time. Define CPUNC_ARB_RR_EN for round-robin, else req0 has priority.
module cpunc_axi_arb
  import cpunc_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                                CPUNC_ACLK,
  input  logic                                CPUNC_ARESET,
  input  logic [NUM_REQ-1:0]                  REQ_VALID,
  output logic [NUM_REQ-1:0]                  REQ_READY,
  input  logic [NUM_REQ-1:0]                  REQ_WE,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   REQ_WDATA,
  input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic [NUM_REQ-1:0]                  RSP_VALID,
  output logic [AXI_DATA_WIDTH-1:0]           RSP_RDATA,
  output logic                                RSP_ERR,
  output logic [AXI_ADDR_WIDTH-1:0]           CPUNC_AWADDR,
  output logic                                CPUNC_AWVALID,
  input  logic                                CPUNC_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]           CPUNC_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]         CPUNC_WSTRB,
  output logic                                CPUNC_WVALID,
  output logic                                CPUNC_WLAST,
  input  logic                                CPUNC_WREADY,
  input  logic                                CPUNC_BRESP,
  input  logic                                CPUNC_BVALID,
  output logic                                CPUNC_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]           CPUNC_ARADDR,
  output logic                                CPUNC_ARVALID,
  input  logic                                CPUNC_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]           CPUNC_RDATA,
  input  logic                                CPUNC_RRESP,
  input  logic                                CPUNC_RVALID,
  output logic                                CPUNC_RREADY
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_gnt_idx;
  logic                w_last;
  logic                r_owner;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [SW-1:0]       r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DW-1:0]       r_rdata;
  logic                r_err;
  logic [AW-1:0]       w_sel_addr;
  logic [DW-1:0]       w_sel_wdata;
  logic [SW-1:0]       w_sel_wstrb;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic [AW-1:0]       w_axaddr;

  // Grants are only offered while idle, which keeps one transaction in flight.
  assign w_req     = (r_state == IDLE) ? REQ_VALID : '0;
  assign w_gnt_idx = w_gnt[1];
  assign REQ_READY = CPUNC_ARESET ? '0 : w_gnt;

  cpunc_rr_pick u_pick (
    .i_req  (w_req),
    .i_last (w_last),
    .o_gnt  (w_gnt)
  );

`ifdef CPUNC_ARB_RR_EN
  logic r_last;

  always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
    if (CPUNC_ARESET) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt_idx;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  assign w_sel_addr  = w_gnt_idx ? REQ_ADDR[2*AW-1:AW]  : REQ_ADDR[AW-1:0];
  assign w_sel_wdata = w_gnt_idx ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
  assign w_sel_wstrb = w_gnt_idx ? REQ_WSTRB[2*SW-1:SW] : REQ_WSTRB[SW-1:0];

  assign w_aw_hs  = CPUNC_AWVALID & CPUNC_AWREADY;
  assign w_w_hs   = CPUNC_WVALID & CPUNC_WREADY;
  assign w_axaddr = r_addr & {{(AW-2){1'b1}}, 2'b00};

  assign CPUNC_AWADDR = w_axaddr;
  assign CPUNC_ARADDR = w_axaddr;
  assign CPUNC_WDATA  = r_wdata;
  assign CPUNC_WSTRB  = r_wstrb;
  assign CPUNC_WLAST  = 1'b1;
  assign RSP_RDATA    = r_rdata;
  assign RSP_ERR      = r_err;

  always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
    if (CPUNC_ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    CPUNC_ARVALID = 1'b0;
    CPUNC_RREADY  = 1'b0;
    CPUNC_AWVALID = 1'b0;
    CPUNC_WVALID  = 1'b0;
    CPUNC_BREADY  = 1'b0;
    RSP_VALID     = '0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_next = REQ_WE[w_gnt_idx] ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      RD_ADDR: begin
        CPUNC_ARVALID = 1'b1;
        if (CPUNC_ARREADY) w_next = RD_DATA;
      end
      RD_DATA: begin
        CPUNC_RREADY = 1'b1;
        if (CPUNC_RVALID) w_next = RSP;
      end
      WR_ADDR_DATA: begin
        CPUNC_AWVALID = ~r_aw_done;
        CPUNC_WVALID  = ~r_w_done;
        if ((r_aw_done | CPUNC_AWREADY) && (r_w_done | CPUNC_WREADY)) begin
          w_next = WR_RESP;
        end
      end
      WR_RESP: begin
        CPUNC_BREADY = 1'b1;
        if (CPUNC_BVALID) w_next = RSP;
      end
      RSP: begin
        RSP_VALID = r_owner ? 2'b10 : 2'b01;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Payload is captured at grant; completion data is captured on the R/B handshake.
  always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
    if (CPUNC_ARESET) begin
      r_owner   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == IDLE && (|w_gnt)) begin
        r_owner   <= w_gnt_idx;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_wstrb   <= w_sel_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == WR_ADDR_DATA) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if (r_state == RD_DATA && CPUNC_RVALID) begin
        r_rdata <= CPUNC_RDATA;
        r_err   <= (CPUNC_RRESP != OKAY);
      end
      if (r_state == WR_RESP && CPUNC_BVALID) begin
        r_rdata <= '0;
        r_err   <= (CPUNC_BRESP != OKAY);
      end
    end
  end

endmodule

// File: tb/tb_cpunc_axi_arb.sv
// Self-checking bench for cpunc_axi_arb: directed scenarios plus randomized
// transactions against a cycle-count reference model and a behavioural AXI slave.
module tb_cpunc_axi_arb;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      REQ_VALID, REQ_READY, REQ_WE, RSP_VALID;
  logic [2*AW-1:0] REQ_ADDR;
  logic [2*DW-1:0] REQ_WDATA;
  logic [2*SW-1:0] REQ_WSTRB;
  logic [DW-1:0]   RSP_RDATA, WDATA, RDATA;
  logic            RSP_ERR;
  logic [AW-1:0]   AWADDR, ARADDR;
  logic [SW-1:0]   WSTRB;
  logic            AWVALID, AWREADY, WVALID, WLAST, WREADY, BRESP, BVALID, BREADY;
  logic            ARVALID, ARREADY, RRESP, RVALID, RREADY;

  int total = 0;
  int bad   = 0;

  int          ar_wait, aw_wait, w_wait, r_wait, b_wait;
  logic [31:0] s_rdata;
  logic        s_rresp, s_bresp;
  logic        m_last;

  always #5 clk = ~clk;

  cpunc_axi_arb #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .CPUNC_ACLK(clk), .CPUNC_ARESET(rst),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .CPUNC_AWADDR(AWADDR), .CPUNC_AWVALID(AWVALID), .CPUNC_AWREADY(AWREADY),
    .CPUNC_WDATA(WDATA), .CPUNC_WSTRB(WSTRB), .CPUNC_WVALID(WVALID),
    .CPUNC_WLAST(WLAST), .CPUNC_WREADY(WREADY),
    .CPUNC_BRESP(BRESP), .CPUNC_BVALID(BVALID), .CPUNC_BREADY(BREADY),
    .CPUNC_ARADDR(ARADDR), .CPUNC_ARVALID(ARVALID), .CPUNC_ARREADY(ARREADY),
    .CPUNC_RDATA(RDATA), .CPUNC_RRESP(RRESP), .CPUNC_RVALID(RVALID),
    .CPUNC_RREADY(RREADY)
  );

  // Expected winner from the arbitration rule.
  function automatic logic [1:0] model_pick(input logic [1:0] v, input logic last);
`ifdef CPUNC_ARB_RR_EN
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
`else
    if (v == 2'b11) return 2'b01;
`endif
    return v;
  endfunction

  // Behavioural slave: each ready/valid answers after a configurable number of wait cycles.
  initial begin
    int ar_c, aw_c, w_c, r_c, b_c;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
    RDATA = '0; RRESP = 0; BRESP = 0;
    forever begin
      @(negedge clk);
      if (ARVALID) begin ARREADY = (ar_c >= ar_wait); ar_c++; end
      else begin ARREADY = 0; ar_c = 0; end
      if (AWVALID) begin AWREADY = (aw_c >= aw_wait); aw_c++; end
      else begin AWREADY = 0; aw_c = 0; end
      if (WVALID) begin WREADY = (w_c >= w_wait); w_c++; end
      else begin WREADY = 0; w_c = 0; end
      if (RREADY) begin RVALID = (r_c >= r_wait); RDATA = s_rdata; RRESP = s_rresp; r_c++; end
      else begin RVALID = 0; r_c = 0; end
      if (BREADY) begin BVALID = (b_c >= b_wait); BRESP = s_bresp; b_c++; end
      else begin BVALID = 0; b_c = 0; end
    end
  end

  // Raise a request mask, wait for the grant handshake, then observe the transaction.
  task automatic run_txn(input logic [1:0] vmask, output bit to, output int gw,
                         output logic [1:0] gnt, output int lat, output logic [1:0] rsp,
                         output logic [31:0] rdata, output logic err,
                         output logic [AW-1:0] araddr, output logic [AW-1:0] awaddr,
                         output logic [SW-1:0] wstrb, output logic [31:0] wdata,
                         output int aw_hi, output int w_hi, output int npulse);
    bit got;
    to = 0; gw = 0; gnt = 0; lat = 0; rsp = 0; rdata = 0; err = 0;
    araddr = 0; awaddr = 0; wstrb = 0; wdata = 0; aw_hi = 0; w_hi = 0; npulse = 0;
    got = 0;
    @(negedge clk);
    REQ_VALID = vmask;
    #1;
    while (!(|(REQ_READY & REQ_VALID)) && gw < 50) begin
      @(negedge clk); #1; gw++;
    end
    if (!(|(REQ_READY & REQ_VALID))) begin
      to = 1; REQ_VALID = 0; return;
    end
    gnt = REQ_READY;
    @(posedge clk); #1;
    REQ_VALID = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (AWVALID) begin aw_hi++; awaddr = AWADDR; end
      if (WVALID)  begin w_hi++; wstrb = WSTRB; wdata = WDATA; end
      if (ARVALID) araddr = ARADDR;
      if (RSP_VALID != 2'b00) begin
        npulse++;
        if (!got) begin got = 1; lat = k; rsp = RSP_VALID; rdata = RSP_RDATA; err = RSP_ERR; end
      end
      if (got && k >= lat + 2) break;
    end
    if (!got) to = 1;
  endtask

  task automatic zero_waits();
    ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
    s_rresp = 0; s_bresp = 0; s_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; REQ_VALID = 2'b11; REQ_WE = 0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    zero_waits();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({REQ_READY, ARVALID, AWVALID, WVALID, BREADY, RREADY, RSP_VALID} !== 9'd0) begin
      bad++; $display("FAIL reset_handshakes got=%b want=0",
        {REQ_READY, ARVALID, AWVALID, WVALID, BREADY, RREADY, RSP_VALID});
    end
    total++;
    if ({AWADDR, ARADDR, WDATA, WSTRB, RSP_RDATA, RSP_ERR} !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {AWADDR, ARADDR, WDATA, WSTRB, RSP_RDATA, RSP_ERR});
    end
    total++;
    if (WLAST !== 1'b1) begin bad++; $display("FAIL wlast got=%b want=1", WLAST); end
    @(negedge clk);
    REQ_VALID = 0; rst = 0;
    m_last = 1;
  endtask

  task automatic test_read();
    bit to; int gw, lat, awh, wh, np; logic [1:0] g, r; logic [31:0] rd, wd; logic e;
    logic [AW-1:0] ara, awa; logic [SW-1:0] ws;
    zero_waits(); s_rdata = 32'hDEADBEEF;
    REQ_WE = 2'b00; REQ_ADDR[AW-1:0] = 12'h104;
    run_txn(2'b01, to, gw, g, lat, r, rd, e, ara, awa, ws, wd, awh, wh, np);
    m_last = 0;
    total++; if (to !== 0) begin bad++; $display("FAIL read_timeout got=%0d want=0", to); end
    total++; if (g !== 2'b01) begin bad++; $display("FAIL read_grant got=%b want=01", g); end
    total++; if (ara !== 12'h104) begin bad++; $display("FAIL read_araddr got=%h want=104", ara); end
    total++; if (lat !== 3) begin bad++; $display("FAIL read_latency got=%0d want=3", lat); end
    total++; if (r !== 2'b01) begin bad++; $display("FAIL read_rspvalid got=%b want=01", r); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h want=deadbeef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL read_err got=%b want=0", e); end
    total++; if (np !== 1) begin bad++; $display("FAIL read_pulses got=%0d want=1", np); end
  endtask

  task automatic test_write();
    bit to; int gw, lat, awh, wh, np; logic [1:0] g, r; logic [31:0] rd, wd; logic e;
    logic [AW-1:0] ara, awa; logic [SW-1:0] ws;
    zero_waits(); w_wait = 2;
    REQ_WE = 2'b10; REQ_ADDR[2*AW-1:AW] = 12'h20A;
    REQ_WDATA[2*DW-1:DW] = 32'h11223344; REQ_WSTRB[2*SW-1:SW] = 4'hC;
    run_txn(2'b10, to, gw, g, lat, r, rd, e, ara, awa, ws, wd, awh, wh, np);
    m_last = 1;
    total++; if (to !== 0) begin bad++; $display("FAIL write_timeout got=%0d want=0", to); end
    total++; if (g !== 2'b10) begin bad++; $display("FAIL write_grant got=%b want=10", g); end
    total++; if (awa !== 12'h208) begin bad++; $display("FAIL write_awaddr got=%h want=208", awa); end
    total++; if (ws !== 4'hC) begin bad++; $display("FAIL write_wstrb got=%h want=c", ws); end
    total++; if (wd !== 32'h11223344) begin bad++; $display("FAIL write_wdata got=%h want=11223344", wd); end
    total++; if (awh !== 1 || wh !== 3) begin
      bad++; $display("FAIL write_aw_first got aw=%0d w=%0d want aw=1 w=3", awh, wh);
    end
    total++; if (r !== 2'b10 || np !== 1) begin
      bad++; $display("FAIL write_rsp got=%b x%0d want=10 x1", r, np);
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL write_latency got=%0d want=5", lat); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL write_rdata got=%h want=0", rd); end
  endtask

  task automatic test_arbitration();
    bit to; int gw, lat, awh, wh, np; logic [1:0] g, r, exp; logic [31:0] rd, wd; logic e;
    logic [AW-1:0] ara, awa; logic [SW-1:0] ws;
    zero_waits();
    REQ_WE = 2'b00; REQ_ADDR = {12'h300, 12'h100};
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'hA0 + i;
      exp = model_pick(2'b11, m_last);
      m_last = exp[1];
      run_txn(2'b11, to, gw, g, lat, r, rd, e, ara, awa, ws, wd, awh, wh, np);
      total++;
      if (to !== 0 || g !== exp || r !== exp) begin
        bad++; $display("FAIL arb_grant_%0d got gnt=%b rsp=%b to=%0d want=%b", i, g, r, to, exp);
      end
    end
  endtask

  task automatic test_error();
    bit to; int gw, lat, awh, wh, np; logic [1:0] g, r; logic [31:0] rd, wd; logic e;
    logic [AW-1:0] ara, awa; logic [SW-1:0] ws;
    zero_waits(); s_bresp = 1;
    REQ_WE = 2'b01; REQ_ADDR[AW-1:0] = 12'h010; REQ_WDATA[DW-1:0] = 32'h5; REQ_WSTRB[SW-1:0] = 4'hF;
    run_txn(2'b01, to, gw, g, lat, r, rd, e, ara, awa, ws, wd, awh, wh, np);
    m_last = 0;
    total++; if (to !== 0 || r !== 2'b01 || e !== 1'b1) begin
      bad++; $display("FAIL bresp_err got rsp=%b err=%b to=%0d want rsp=01 err=1", r, e, to);
    end
    zero_waits(); s_rdata = 32'h600D;
    REQ_WE = 2'b00;
    run_txn(2'b01, to, gw, g, lat, r, rd, e, ara, awa, ws, wd, awh, wh, np);
    m_last = 0;
    total++; if (gw !== 0 || lat !== 3 || rd !== 32'h600D || e !== 0) begin
      bad++; $display("FAIL after_err_idle got wait=%0d lat=%0d rdata=%h err=%b want 0/3/600d/0", gw, lat, rd, e);
    end
  endtask

  task automatic test_reset_inflight();
    bit to; int gw, lat, awh, wh, np, n; logic [1:0] g, r; logic [31:0] rd, wd; logic e;
    logic [AW-1:0] ara, awa; logic [SW-1:0] ws;
    zero_waits(); r_wait = 30;
    REQ_WE = 2'b00; REQ_ADDR[AW-1:0] = 12'h0F0;
    @(negedge clk); REQ_VALID = 2'b01;
    @(posedge clk); #1; REQ_VALID = 0;
    n = 0;
    while (!RREADY && n < 20) begin @(negedge clk); n++; end
    total++; if (RREADY !== 1'b1) begin bad++; $display("FAIL inflight_rd_data got rready=%b want=1", RREADY); end
    #1 rst = 1;
    #1;
    total++;
    if ({ARVALID, RREADY, RSP_VALID, AWVALID, WVALID, BREADY, REQ_READY} !== 9'd0) begin
      bad++; $display("FAIL async_reset got=%b want=0",
        {ARVALID, RREADY, RSP_VALID, AWVALID, WVALID, BREADY, REQ_READY});
    end
    repeat (2) @(negedge clk);
    rst = 0; m_last = 1;
    zero_waits(); s_rdata = 32'hCAFE0001;
    REQ_ADDR[AW-1:0] = 12'h03C;
    run_txn(2'b01, to, gw, g, lat, r, rd, e, ara, awa, ws, wd, awh, wh, np);
    m_last = 0;
    total++; if (to !== 0 || r !== 2'b01 || lat !== 3 || rd !== 32'hCAFE0001 || ara !== 12'h03C || np !== 1) begin
      bad++; $display("FAIL post_reset_read got rsp=%b lat=%0d rdata=%h araddr=%h n=%0d", r, lat, rd, ara, np);
    end
  endtask

  task automatic test_random();
    bit to; int gw, lat, awh, wh, np, elat; logic [1:0] g, r, v, exp; logic [31:0] rd, wd, ewd;
    logic e, ee, we; logic [AW-1:0] ara, awa, ea; logic [SW-1:0] ws, ews;
    for (int i = 0; i < 24; i++) begin
      v = 2'($urandom_range(1, 3));
      REQ_WE = 2'($urandom); REQ_ADDR = 24'($urandom);
      REQ_WDATA = {$urandom, $urandom}; REQ_WSTRB = 8'($urandom);
      ar_wait = $urandom_range(0, 3); aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
      r_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
      s_rdata = $urandom; s_rresp = ($urandom_range(0, 3) == 0); s_bresp = ($urandom_range(0, 3) == 0);
      exp = model_pick(v, m_last);
      m_last = exp[1];
      we  = REQ_WE[exp[1]];
      ea  = (exp[1] ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0]) & 12'hFFC;
      ewd = exp[1] ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
      ews = exp[1] ? REQ_WSTRB[2*SW-1:SW] : REQ_WSTRB[SW-1:0];
      elat = we ? 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait : 3 + ar_wait + r_wait;
      ee = we ? s_bresp : s_rresp;
      run_txn(v, to, gw, g, lat, r, rd, e, ara, awa, ws, wd, awh, wh, np);
      total++;
      if (to !== 0 || g !== exp || r !== exp || np !== 1) begin
        bad++; $display("FAIL rnd%0d_grant got gnt=%b rsp=%b n=%0d to=%0d want=%b", i, g, r, np, to, exp);
      end
      total++;
      if (lat !== elat || e !== ee) begin
        bad++; $display("FAIL rnd%0d_timing got lat=%0d err=%b want lat=%0d err=%b", i, lat, e, elat, ee);
      end
      total++;
      if (we) begin
        if (awa !== ea || ws !== ews || wd !== ewd || rd !== 32'h0) begin
          bad++; $display("FAIL rnd%0d_write got a=%h s=%h d=%h r=%h want a=%h s=%h d=%h r=0",
                          i, awa, ws, wd, rd, ea, ews, ewd);
        end
      end else begin
        if (ara !== ea || rd !== s_rdata || awh !== 0) begin
          bad++; $display("FAIL rnd%0d_read got a=%h r=%h aw=%0d want a=%h r=%h aw=0", i, ara, rd, awh, ea, s_rdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_error();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
